// File: rtl/stack_engine.sv
// stack_engine: owns the stack pointer and sequences multi-word push/pop
// transfers over a narrow single-port data/stack memory.
// Optional compile-time feature: define STACK_BOUNDS_CHECK_EN to reject
// pushes that would exceed STACK_DEPTH and pops from an under-filled stack.
module stack_engine #(
    parameter int DATA_W      = 16,
    parameter int VALUE_W     = 32,
    parameter int ADDR_W      = 11,
    parameter int SP_RESET    = 2047,
    parameter int STACK_DEPTH = 1024,
    localparam int WORDS      = VALUE_W / DATA_W,
    localparam int CNT_W      = $clog2(WORDS + 1),
    localparam int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_req,
    input  logic               pop_req,
    input  logic [CNT_W-1:0]   req_words,
    input  logic [VALUE_W-1:0] push_value,
    output logic [VALUE_W-1:0] pop_value,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  sp,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_write_en,
    output logic [DATA_W-1:0]  mem_write_data,
    output logic               mem_read_en,
    input  logic [DATA_W-1:0]  mem_read_data,
    output logic               overflow_err,
    output logic               underflow_err
);

    typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP_RD, S_POP_LAST, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             sp_q, sp_d;
    logic [CNT_W-1:0]              n_q, n_d, n_eff;
    logic [IDX_W-1:0]              k_q, k_d, last_idx;
    logic [WORDS-1:0][DATA_W-1:0]  val_q, val_d, pv_q, pv_d;
    logic                          ovf_q, ovf_d, unf_q, unf_d;
    logic                          ovf_hit, unf_hit, accept_push, accept_pop;

    // Word count normalisation: 0 means one word, anything above WORDS is clamped
    always_comb begin
        n_eff = req_words;
        if (req_words == '0)
            n_eff = CNT_W'(1);
        else if (req_words > CNT_W'(WORDS))
            n_eff = CNT_W'(WORDS);
    end

    assign last_idx = IDX_W'(n_q - 1'b1);

`ifdef STACK_BOUNDS_CHECK_EN
    // Occupancy check against the pre-transfer stack pointer
    always_comb begin
        int used;
        used    = SP_RESET - int'(sp_q);
        ovf_hit = (used + int'(n_eff)) > STACK_DEPTH;
        unf_hit = used < int'(n_eff);
    end
`else
    assign ovf_hit = 1'b0;
    assign unf_hit = 1'b0;
`endif

    // Push has priority; a pop seen together with a push is simply dropped
    assign accept_push = (state_q == S_IDLE) && push_req && !ovf_hit;
    assign accept_pop  = (state_q == S_IDLE) && !push_req && pop_req && !unf_hit;
    assign ovf_d       = (state_q == S_IDLE) && push_req && ovf_hit;
    assign unf_d       = (state_q == S_IDLE) && !push_req && pop_req && unf_hit;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sp_q    <= ADDR_W'(SP_RESET);
            n_q     <= '0;
            k_q     <= '0;
            val_q   <= '0;
            pv_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            n_q     <= n_d;
            k_q     <= k_d;
            val_q   <= val_d;
            pv_q    <= pv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept_push) state_d = S_PUSH;
                        else if (accept_pop) state_d = S_POP_RD;
            S_PUSH:     if (k_q == last_idx) state_d = S_DONE;
            S_POP_RD:   if (k_q == last_idx) state_d = S_POP_LAST;
            S_POP_LAST: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath: SP stepping, word counter, value latch and pop capture
    // (read data lags its strobe by one cycle, so capture index is k-1)
    always_comb begin
        sp_d  = sp_q;
        n_d   = n_q;
        k_d   = k_q;
        val_d = val_q;
        pv_d  = pv_q;
        if (accept_push) begin
            n_d   = n_eff;
            k_d   = '0;
            val_d = push_value;
        end
        if (accept_pop) begin
            n_d = n_eff;
            k_d = '0;
            for (int w = 0; w < WORDS; w++)
                if (w >= int'(n_eff)) pv_d[w] = '0;
        end
        case (state_q)
            S_PUSH: begin
                sp_d = sp_q - 1'b1;
                k_d  = k_q + 1'b1;
            end
            S_POP_RD: begin
                sp_d = sp_q + 1'b1;
                k_d  = k_q + 1'b1;
                if (k_q != '0) pv_d[k_q - 1'b1] = mem_read_data;
            end
            S_POP_LAST: pv_d[last_idx] = mem_read_data;
            default: ;
        endcase
    end

    // Outputs decoded from state; push emits most significant word first
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state_q)
            S_PUSH: begin
                mem_write_en   = 1'b1;
                mem_address    = sp_q;
                mem_write_data = val_q[last_idx - k_q];
            end
            S_POP_RD: begin
                mem_read_en = 1'b1;
                mem_address = sp_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign sp            = sp_q;
    assign pop_value     = pv_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: directed scenarios plus randomized
// push/pop traffic checked against an address-level stack model.
module tb_stack_engine;

    logic        clk = 1'b0;
    logic        reset, push_req, pop_req;
    logic [1:0]  req_words;
    logic [31:0] push_value, pop_value;
    logic        busy, done;
    logic [10:0] sp, mem_address;
    logic        mem_write_en, mem_read_en;
    logic [15:0] mem_write_data, mem_read_data;
    logic        overflow_err, underflow_err;
    logic        mem_clr = 1'b0;

    int vecs = 0, errs = 0;

    logic [15:0] mem     [0:2047];
    logic [15:0] ref_mem [0:2047];
    int          ref_sp;
    logic [31:0] ref_pv;
    logic [63:0] wlog, rlog;
    int          wcnt, rcnt, both_hi;

    stack_engine dut (
        .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req),
        .req_words(req_words), .push_value(push_value), .pop_value(pop_value),
        .busy(busy), .done(done), .sp(sp), .mem_address(mem_address),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_en(mem_read_en), .mem_read_data(mem_read_data),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < 2048; i++) mem[i] <= 16'h0;
        if (mem_write_en) mem[mem_address] <= mem_write_data;
        if (mem_read_en) mem_read_data <= mem[mem_address];
    end

    // Reference: push of N words stores MS word at sp, next at sp-1, ...
    task automatic m_push(input logic [31:0] v, input int n, output logic [63:0] exp_w);
        int ne, a;
        logic [15:0] d;
        ne = (n == 0) ? 1 : n;
        exp_w = '0;
        for (int k = 0; k < ne; k++) begin
            a = (ref_sp - k) & 2047;
            d = v[(ne-1-k)*16 +: 16];
            exp_w = {exp_w[31:0], 5'b0, a[10:0], d};
            ref_mem[a] = d;
        end
        ref_sp = (ref_sp - ne) & 2047;
    endtask

    // Reference: pop reads sp+1.. upward, word k lands in bits [16k +: 16]
    task automatic m_pop(input int n, output logic [63:0] exp_r);
        int ne, a;
        ne = (n == 0) ? 1 : n;
        exp_r = '0;
        ref_pv = '0;
        for (int k = 0; k < ne; k++) begin
            a = (ref_sp + 1 + k) & 2047;
            exp_r = {exp_r[31:0], 21'b0, a[10:0]};
            ref_pv[k*16 +: 16] = ref_mem[a];
        end
        ref_sp = (ref_sp + ne) & 2047;
    endtask

    // Issue one request and log bus activity until done (bounded)
    task automatic xfer(input bit is_push, input bit with_pop, input bit pop_busy,
                        input logic [31:0] val, input logic [1:0] n,
                        output int lat, output bit got_done);
        wlog = '0; rlog = '0; wcnt = 0; rcnt = 0; both_hi = 0;
        got_done = 1'b0; lat = 0;
        @(negedge clk);
        push_req = is_push; pop_req = !is_push || with_pop; req_words = n; push_value = val;
        @(negedge clk);
        push_req = 1'b0; pop_req = pop_busy; push_value = $urandom; req_words = 2'($urandom);
        for (int c = 1; c <= 12; c++) begin
            if (mem_write_en) begin wlog = {wlog[31:0], 5'b0, mem_address, mem_write_data}; wcnt++; end
            if (mem_read_en) begin rlog = {rlog[31:0], 21'b0, mem_address}; rcnt++; end
            if (mem_write_en && mem_read_en) both_hi++;
            if (done) begin got_done = 1'b1; lat = c; break; end
            @(negedge clk);
        end
        pop_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ref_sp = 2047; ref_pv = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; push_req = 1'b0; pop_req = 1'b0; req_words = '0; push_value = '0;
        mem_clr = 1'b1;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 16'h0;
        ref_sp = 2047; ref_pv = '0;
        vecs++; if (sp !== 11'd2047) begin errs++; $display("FAIL reset_sp got %0d want 2047", sp); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done); end
        vecs++; if ({mem_write_en, mem_read_en} !== 2'b00) begin errs++; $display("FAIL reset_strobes got %b want 00", {mem_write_en, mem_read_en}); end
        vecs++; if (mem_address !== 11'd0) begin errs++; $display("FAIL reset_addr got %0d want 0", mem_address); end
        vecs++; if (pop_value !== 32'h0) begin errs++; $display("FAIL reset_popval got %h want 0", pop_value); end
        vecs++; if ({overflow_err, underflow_err} !== 2'b00) begin errs++; $display("FAIL reset_err got %b want 00", {overflow_err, underflow_err}); end
        reset = 1'b0;
    endtask

    task automatic test_push_pop_2();
        int lat; bit gd; logic [63:0] ex;
        xfer(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 2'd2, lat, gd);
        m_push(32'hDEADBEEF, 2, ex);
        vecs++; if (wlog !== {5'b0, 11'd2047, 16'hDEAD, 5'b0, 11'd2046, 16'hBEEF}) begin errs++; $display("FAIL push2_writes got %h want %h", wlog, ex); end
        vecs++; if (rcnt !== 0) begin errs++; $display("FAIL push2_reads got %0d want 0", rcnt); end
        vecs++; if (sp !== 11'd2045) begin errs++; $display("FAIL push2_sp got %0d want 2045", sp); end
        vecs++; if (lat !== 3) begin errs++; $display("FAIL push2_latency got %0d want 3", lat); end
        xfer(1'b0, 1'b0, 1'b0, 32'h0, 2'd2, lat, gd);
        m_pop(2, ex);
        vecs++; if (rlog !== {21'b0, 11'd2046, 21'b0, 11'd2047}) begin errs++; $display("FAIL pop2_reads got %h want %h", rlog, ex); end
        vecs++; if (pop_value !== 32'hDEADBEEF) begin errs++; $display("FAIL pop2_value got %h want deadbeef", pop_value); end
        vecs++; if (sp !== 11'd2047) begin errs++; $display("FAIL pop2_sp got %0d want 2047", sp); end
        vecs++; if (lat !== 4) begin errs++; $display("FAIL pop2_latency got %0d want 4", lat); end
    endtask

    task automatic test_single();
        int lat; bit gd; logic [63:0] ex;
        xfer(1'b1, 1'b0, 1'b0, 32'h55AA1234, 2'd1, lat, gd);
        m_push(32'h55AA1234, 1, ex);
        vecs++; if (wcnt !== 1 || wlog !== ex) begin errs++; $display("FAIL push1_writes got %0d/%h want 1/%h", wcnt, wlog, ex); end
        vecs++; if (lat !== 2) begin errs++; $display("FAIL push1_latency got %0d want 2", lat); end
        xfer(1'b0, 1'b0, 1'b0, 32'h0, 2'd1, lat, gd);
        m_pop(1, ex);
        vecs++; if (pop_value !== 32'h00001234) begin errs++; $display("FAIL pop1_value got %h want 00001234", pop_value); end
        vecs++; if (sp !== 11'(ref_sp) || lat !== 3) begin errs++; $display("FAIL pop1_sp_lat got %0d/%0d want %0d/3", sp, lat, ref_sp); end
    endtask

    task automatic test_conflict();
        int lat; bit gd; logic [63:0] ex;
        xfer(1'b1, 1'b1, 1'b0, 32'h0BADF00D, 2'd2, lat, gd);
        m_push(32'h0BADF00D, 2, ex);
        vecs++; if (rcnt !== 0 || wlog !== ex) begin errs++; $display("FAIL both_req got reads %0d writes %h want 0/%h", rcnt, wlog, ex); end
        vecs++; if (sp !== 11'(ref_sp)) begin errs++; $display("FAIL both_req_sp got %0d want %0d", sp, ref_sp); end
        xfer(1'b1, 1'b0, 1'b1, 32'h00007777, 2'd1, lat, gd);
        m_push(32'h00007777, 1, ex);
        repeat (2) @(negedge clk);
        vecs++; if (rcnt !== 0 || busy !== 1'b0) begin errs++; $display("FAIL pop_while_busy got reads %0d busy %b want 0/0", rcnt, busy); end
        vecs++; if (sp !== 11'(ref_sp)) begin errs++; $display("FAIL pop_while_busy_sp got %0d want %0d", sp, ref_sp); end
    endtask

    task automatic test_random();
        int lat, depth, n, ne, exp_lat; bit gd, is_push; logic [31:0] v; logic [63:0] ex;
        for (int i = 0; i < 40; i++) begin
            depth = 2047 - ref_sp;
            n = $urandom_range(0, 2);
            ne = (n == 0) ? 1 : n;
            is_push = (depth < ne) || ($urandom % 2 == 0);
            v = $urandom;
            if (is_push) begin
                xfer(1'b1, ($urandom % 4) == 0, 1'b0, v, 2'(n), lat, gd);
                m_push(v, n, ex);
                exp_lat = ne + 1;
                vecs++; if (wlog !== ex || rcnt !== 0) begin errs++; $display("FAIL rnd%0d_push_bus got %h/%0d want %h/0", i, wlog, rcnt, ex); end
            end else begin
                xfer(1'b0, 1'b0, 1'b0, v, 2'(n), lat, gd);
                m_pop(n, ex);
                exp_lat = ne + 2;
                vecs++; if (rlog !== ex || wcnt !== 0) begin errs++; $display("FAIL rnd%0d_pop_bus got %h/%0d want %h/0", i, rlog, wcnt, ex); end
            end
            vecs++; if (pop_value !== ref_pv) begin errs++; $display("FAIL rnd%0d_popval got %h want %h", i, pop_value, ref_pv); end
            vecs++; if (sp !== 11'(ref_sp)) begin errs++; $display("FAIL rnd%0d_sp got %0d want %0d", i, sp, ref_sp); end
            vecs++; if (lat !== exp_lat || both_hi !== 0) begin errs++; $display("FAIL rnd%0d_lat got %0d (overlap %0d) want %0d", i, lat, both_hi, exp_lat); end
        end
    endtask

    task automatic test_mid_reset();
        int a, seen_done;
        do_reset();
        a = ref_sp;
        @(negedge clk);
        push_req = 1'b1; req_words = 2'd2; push_value = 32'hCAFEF00D;
        @(negedge clk);
        push_req = 1'b0;
        vecs++; if (mem_write_en !== 1'b1 || mem_address !== 11'(a)) begin errs++; $display("FAIL midrst_first_write got %b@%0d want 1@%0d", mem_write_en, mem_address, a); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_mem[a] = 16'hCAFE; ref_sp = 2047; ref_pv = '0;
        vecs++; if (sp !== 11'd2047 || busy !== 1'b0) begin errs++; $display("FAIL midrst_state got sp %0d busy %b want 2047/0", sp, busy); end
        vecs++; if (mem[a] !== 16'hCAFE) begin errs++; $display("FAIL midrst_kept_write got %h want cafe", mem[a]); end
        seen_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        vecs++; if (seen_done !== 0) begin errs++; $display("FAIL midrst_no_done got %0d want 0", seen_done); end
    endtask

    task automatic test_bounds();
        int lat; bit gd; logic [63:0] ex;
        do_reset();
`ifdef STACK_BOUNDS_CHECK_EN
        begin
            int fill_bad;
            @(negedge clk);
            pop_req = 1'b1; req_words = 2'd1;
            @(negedge clk);
            pop_req = 1'b0;
            vecs++; if (underflow_err !== 1'b1 || mem_read_en !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL underflow_pulse got err %b rd %b busy %b want 1/0/0", underflow_err, mem_read_en, busy); end
            @(negedge clk);
            vecs++; if (underflow_err !== 1'b0 || sp !== 11'd2047) begin errs++; $display("FAIL underflow_after got err %b sp %0d want 0/2047", underflow_err, sp); end
            fill_bad = 0;
            for (int i = 0; i < 512; i++) begin
                xfer(1'b1, 1'b0, 1'b0, $urandom, 2'd2, lat, gd);
                m_push(32'h0, 2, ex);
                if (!gd) fill_bad++;
            end
            vecs++; if (fill_bad !== 0 || sp !== 11'd1023) begin errs++; $display("FAIL fill got %0d missing done sp %0d want 0/1023", fill_bad, sp); end
            @(negedge clk);
            push_req = 1'b1; req_words = 2'd1;
            @(negedge clk);
            push_req = 1'b0;
            vecs++; if (overflow_err !== 1'b1 || mem_write_en !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL overflow_pulse got err %b wr %b busy %b want 1/0/0", overflow_err, mem_write_en, busy); end
            @(negedge clk);
            vecs++; if (overflow_err !== 1'b0 || sp !== 11'd1023) begin errs++; $display("FAIL overflow_after got err %b sp %0d want 0/1023", overflow_err, sp); end
            do_reset();
        end
`else
        xfer(1'b0, 1'b0, 1'b0, 32'h0, 2'd1, lat, gd);
        m_pop(1, ex);
        vecs++; if (rlog !== ex || sp !== 11'd0 || !gd) begin errs++; $display("FAIL wrap_pop got %h sp %0d done %b want %h/0/1", rlog, sp, gd, ex); end
        vecs++; if (underflow_err !== 1'b0) begin errs++; $display("FAIL wrap_no_err got %b want 0", underflow_err); end
        xfer(1'b1, 1'b0, 1'b0, 32'h0000ABCD, 2'd1, lat, gd);
        m_push(32'h0000ABCD, 1, ex);
        vecs++; if (wlog !== ex || sp !== 11'd2047) begin errs++; $display("FAIL wrap_push got %h sp %0d want %h/2047", wlog, sp, ex); end
`endif
    endtask

    initial begin
        test_reset();
        test_push_pop_2();
        test_single();
        test_conflict();
        test_random();
        test_mid_reset();
        test_bounds();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
